// File: rtl/tlbarray_pkg.sv
// Shared MMU types for the TLB data array and its flush walker.
package cvw;
    localparam int PPN_W  = 44;
    localparam int ASID_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } tlbflush_state_t;

    typedef struct packed {
        logic [PPN_W-1:0]  ppn;
        logic [7:0]        access;
        logic              g;
        logic [ASID_W-1:0] asid;
    } tlb_entry_t;
endpackage

// File: rtl/tlbarray_if.sv
// Request/response bundle between the MMU and the TLB data array.
interface tlbarray_if #(
    parameter int XLEN        = 64,
    parameter int PPN_BITS    = 44,
    parameter int ASID_BITS   = 16,
    parameter int TLB_ENTRIES = 16
);
    logic [XLEN-1:0]                PTE;
    logic [ASID_BITS-1:0]           WriteASID;
    logic                           WriteEn;
    logic [TLB_ENTRIES-1:0]         Matches;
    logic                           Hit;
    logic                           FlushReq;
    logic                           FlushAll;
    logic [ASID_BITS-1:0]           FlushASID;
    logic [PPN_BITS-1:0]            PPN;
    logic [7:0]                     PTEAccessBits;
    logic [TLB_ENTRIES-1:0]         PTE_Gs;
    logic [TLB_ENTRIES-1:0]         Valids;
    logic [$clog2(TLB_ENTRIES)-1:0] Victim;
    logic                           FlushBusy;
    logic                           FlushDone;

    modport master (
        output PTE, WriteASID, WriteEn, Matches, Hit,
        output FlushReq, FlushAll, FlushASID,
        input  PPN, PTEAccessBits, PTE_Gs, Valids, Victim,
        input  FlushBusy, FlushDone
    );

    modport slave (
        input  PTE, WriteASID, WriteEn, Matches, Hit,
        input  FlushReq, FlushAll, FlushASID,
        output PPN, PTEAccessBits, PTE_Gs, Valids, Victim,
        output FlushBusy, FlushDone
    );
endinterface

// File: rtl/tlbplru.sv
// Tree pseudo-LRU victim selector, used when TLB_PLRU_EN is defined.
module tlbplru #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 touch_en,
    input  logic [$clog2(N)-1:0] touch_idx,
    output logic [$clog2(N)-1:0] victim
);
    localparam int IDX = $clog2(N);

    // heap order: node k has children 2k and 2k+1; bit 1 means go right
    logic [N-1:1] tree, tree_n;
    logic [IDX:0] vn, tn;
    logic         unused_msb;

    always_comb begin
        vn = (IDX+1)'(1);
        for (int l = 0; l < IDX; l++)
            vn = {vn[IDX-1:0], tree[vn[IDX-1:0]]};
    end

    assign victim = vn[IDX-1:0];

    always_comb begin
        tree_n = tree;
        tn = (IDX+1)'(1);
        for (int l = 0; l < IDX; l++) begin
            tree_n[tn[IDX-1:0]] = ~touch_idx[IDX-1-l];
            tn = {tn[IDX-1:0], touch_idx[IDX-1-l]};
        end
    end

    assign unused_msb = ^{vn[IDX], tn[IDX]};

    always_ff @(posedge clk or negedge reset)
        if (!reset)        tree <= '0;
        else if (touch_en) tree <= tree_n;
endmodule

// File: rtl/tlbarray.sv
// TLB data array with victim selection and ASID/full flush walk.
// Define TLB_PLRU_EN for tree pseudo-LRU; otherwise round-robin.
module tlbarray
    import cvw::*;
#(
    parameter int XLEN        = 64,
    parameter int PPN_BITS    = 44,
    parameter int ASID_BITS   = 16,
    parameter int TLB_ENTRIES = 16
) (
    input logic       clk,
    input logic       reset,
    tlbarray_if.slave bus
);
    localparam int IDX = $clog2(TLB_ENTRIES);

    tlb_entry_t             entry [TLB_ENTRIES];
    tlb_entry_t             new_e;
    logic [TLB_ENTRIES-1:0] valid, gs;
    tlbflush_state_t        state, state_n;
    logic [IDX-1:0]         idx, victim, pol_victim, first_free;
    logic                   fl_all;
    logic [ASID_BITS-1:0]   fl_asid;
    logic                   full, wr, walk_clr;
    logic [PPN_BITS-1:0]    ppn_or;
    logic [7:0]             acc_or;
    logic                   unused_pte;

    assign unused_pte = ^{bus.PTE[XLEN-1:PPN_BITS+10], bus.PTE[9:8]};

    always_comb begin
        new_e.ppn    = bus.PTE[PPN_BITS+9:10];
        new_e.access = bus.PTE[7:0];
        new_e.g      = bus.PTE[5];
        new_e.asid   = bus.WriteASID;
    end

    assign wr = bus.WriteEn && state == IDLE;
    assign walk_clr = state == WALK &&
                      (fl_all || (entry[idx].asid == fl_asid && !entry[idx].g));

    always_ff @(posedge clk)
        if (wr) entry[victim] <= new_e;

    always_ff @(posedge clk or negedge reset)
        if (!reset)        valid <= '0;
        else if (wr)       valid[victim] <= 1'b1;
        else if (walk_clr) valid[idx] <= 1'b0;

    always_comb begin
        ppn_or = '0;
        acc_or = '0;
        gs     = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            gs[i] = valid[i] & entry[i].g;
            if (bus.Matches[i] && valid[i]) begin
                ppn_or |= entry[i].ppn;
                acc_or |= entry[i].access;
            end
        end
    end

    always_comb begin
        first_free = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--)
            if (!valid[i]) first_free = IDX'(i);
    end

    assign full   = &valid;
    assign victim = full ? pol_victim : first_free;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.FlushReq) state_n = WALK;
            WALK:    if (idx == IDX'(TLB_ENTRIES - 1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.FlushBusy = 1'b0;
        bus.FlushDone = 1'b0;
        unique case (state)
            WALK: bus.FlushBusy = 1'b1;
            DONE: begin
                bus.FlushBusy = 1'b1;
                bus.FlushDone = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            idx     <= '0;
            fl_all  <= 1'b0;
            fl_asid <= '0;
        end else if (state == IDLE && bus.FlushReq) begin
            idx     <= '0;
            fl_all  <= bus.FlushAll;
            fl_asid <= bus.FlushASID;
        end else if (state == WALK) begin
            idx <= idx + 1'b1;
        end

`ifdef TLB_PLRU_EN
    logic [TLB_ENTRIES-1:0] hm;
    logic [IDX-1:0]         hit_idx, touch_idx;
    logic                   hit_ok, touch_en;

    always_comb begin
        hm      = bus.Matches & valid;
        hit_idx = '0;
        for (int i = 0; i < TLB_ENTRIES; i++)
            if (hm[i]) hit_idx = IDX'(i);
        hit_ok = bus.Hit && hm != '0 && (hm & (hm - 1'b1)) == '0;
    end

    // a same-cycle write takes precedence over the hit
    assign touch_en  = wr | hit_ok;
    assign touch_idx = wr ? victim : hit_idx;

    tlbplru #(.N(TLB_ENTRIES)) u_plru (
        .clk       (clk),
        .reset     (reset),
        .touch_en  (touch_en),
        .touch_idx (touch_idx),
        .victim    (pol_victim)
    );
`else
    logic [IDX-1:0] rr;
    logic           unused_hit;

    assign unused_hit = bus.Hit;

    always_ff @(posedge clk or negedge reset)
        if (!reset)        rr <= '0;
        else if (wr && full) rr <= rr + 1'b1;

    assign pol_victim = rr;
`endif

    assign bus.PPN           = ppn_or;
    assign bus.PTEAccessBits = acc_or;
    assign bus.PTE_Gs        = gs;
    assign bus.Valids        = valid;
    assign bus.Victim        = victim;
endmodule

// File: tb/tb_tlbarray.sv
// Scoreboard bench for tlbarray.
// Random traffic against an entry model.
module tb_tlbarray;
  localparam int N  = 16;
  localparam int PB = 44;

  typedef enum int {
    K_PPN, K_ACC, K_VALIDS, K_GS, K_VICTIM,
    K_BUSY, K_BUSYCNT, K_DONECNT, K_DROPCNT
  } kind_t;

  typedef struct {
    string       name;
    kind_t       kind;
    logic [63:0] exp;
  } chk_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlbarray_if #(
    .XLEN(64), .PPN_BITS(PB),
    .ASID_BITS(16), .TLB_ENTRIES(N)
  ) bus ();

  tlbarray #(
    .XLEN(64), .PPN_BITS(PB),
    .ASID_BITS(16), .TLB_ENTRIES(N)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  chk_t q[$];
  int   checks   = 0;
  int   passes   = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   drop_cnt = 0;

  logic          m_valid [N];
  logic [PB-1:0] m_ppn   [N];
  logic [7:0]    m_acc   [N];
  logic          m_g     [N];
  logic [15:0]   m_asid  [N];
  int            m_rr;
`ifdef TLB_PLRU_EN
  longint        stamp   [N];
  longint        now;
`endif

  function automatic logic [63:0] act(kind_t k);
    case (k)
      K_PPN:     return 64'(bus.PPN);
      K_ACC:     return 64'(bus.PTEAccessBits);
      K_VALIDS:  return 64'(bus.Valids);
      K_GS:      return 64'(bus.PTE_Gs);
      K_VICTIM:  return 64'(bus.Victim);
      K_BUSY:    return 64'(bus.FlushBusy);
      K_BUSYCNT: return 64'(busy_cnt);
      K_DONECNT: return 64'(done_cnt);
      default:   return 64'(drop_cnt);
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t        c;
    logic [63:0] a;
    if (bus.FlushBusy) busy_cnt++;
    if (bus.FlushDone) done_cnt++;
    if (bus.WriteEn && bus.FlushBusy) drop_cnt++;
    while (q.size() > 0) begin
      c = q.pop_front();
      a = act(c.kind);
      checks++;
      if (a === c.exp) passes++;
      else $display("FAIL %s: got %0h, want %0h",
                    c.name, a, c.exp);
    end
  end

  task automatic chk_now(string n, kind_t k,
                         logic [63:0] e);
    logic [63:0] a;
    a = act(k);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h, want %0h",
                  n, a, e);
  endtask

  function automatic logic [N-1:0] m_valids();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_gs();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      v[i] = m_valid[i] & m_g[i];
    return v;
  endfunction

`ifdef TLB_PLRU_EN
  function automatic int m_plru();
    int     lo, sz, h;
    longint ml, mr;
    lo = 0;
    sz = N;
    while (sz > 1) begin
      h  = sz / 2;
      ml = 0;
      mr = 0;
      for (int i = 0; i < h; i++) begin
        if (stamp[lo+i] > ml) ml = stamp[lo+i];
        if (stamp[lo+h+i] > mr) mr = stamp[lo+h+i];
      end
      if (mr < ml) lo += h;
      sz = h;
    end
    return lo;
  endfunction
`endif

  function automatic int m_victim();
    for (int i = 0; i < N; i++)
      if (!m_valid[i]) return i;
`ifdef TLB_PLRU_EN
    return m_plru();
`else
    return m_rr;
`endif
  endfunction

  function automatic void m_touch(int i);
`ifdef TLB_PLRU_EN
    now++;
    stamp[i] = now;
`else
    if (i < 0) $display("bad touch index");
`endif
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
`ifdef TLB_PLRU_EN
      stamp[i] = 0;
`endif
    end
`ifdef TLB_PLRU_EN
    now = 0;
`endif
    m_rr = 0;
  endfunction

  function automatic logic [PB-1:0] rnd_ppn();
    return PB'({$urandom, $urandom});
  endfunction

  function automatic logic [N-1:0] rnd_match();
    logic [N-1:0] m;
    if ($urandom_range(0, 1) == 1) m = N'($urandom);
    else begin
      m = '0;
      m[$urandom_range(0, N - 1)] = 1'b1;
    end
    return m;
  endfunction

  task automatic want(string n, kind_t k,
                      logic [63:0] e);
    chk_t c;
    c.name = n;
    c.kind = k;
    c.exp  = e;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    want("valids", K_VALIDS, 64'(m_valids()));
    want("gs", K_GS, 64'(m_gs()));
    want("victim", K_VICTIM, 64'(m_victim()));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    m_reset();
    bus.Matches = '1;
    #1;
    chk_now("rst_valids", K_VALIDS, 64'd0);
    chk_now("rst_gs", K_GS, 64'd0);
    chk_now("rst_victim", K_VICTIM, 64'd0);
    chk_now("rst_ppn", K_PPN, 64'd0);
    chk_now("rst_acc", K_ACC, 64'd0);
    chk_now("rst_busy", K_BUSY, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.Matches = '0;
    step();
  endtask

  task automatic do_write(logic [PB-1:0] ppn,
                          logic [7:0] acc, logic g,
                          logic [15:0] asid);
    logic [63:0] pte;
    int          v;
    bit          was_full;
    v = m_victim();
    pte = {$urandom, $urandom};
    pte[PB+9:10] = ppn;
    pte[7:0] = acc;
    pte[5] = g;
    bus.PTE = pte;
    bus.WriteASID = asid;
    bus.WriteEn = 1'b1;
    want("wr_victim", K_VICTIM, 64'(v));
    step();
    bus.WriteEn = 1'b0;
    was_full = &m_valids();
    if (was_full) m_rr = (m_rr + 1) % N;
    m_valid[v] = 1'b1;
    m_ppn[v] = ppn;
    m_acc[v] = pte[7:0];
    m_g[v] = g;
    m_asid[v] = asid;
    m_touch(v);
  endtask

  task automatic do_read(logic [N-1:0] m);
    logic [PB-1:0] p;
    logic [7:0]    a;
    p = '0;
    a = '0;
    for (int i = 0; i < N; i++)
      if (m[i] && m_valid[i]) begin
        p |= m_ppn[i];
        a |= m_acc[i];
      end
    bus.Matches = m;
    want("read_ppn", K_PPN, 64'(p));
    want("read_acc", K_ACC, 64'(a));
    step();
  endtask

  task automatic do_hit(int i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    bus.Matches = m;
    bus.Hit = 1'b1;
    want("hit_ppn", K_PPN,
         m_valid[i] ? 64'(m_ppn[i]) : 64'd0);
    step();
    bus.Hit = 1'b0;
    if (m_valid[i]) m_touch(i);
  endtask

  task automatic flush(bit all, logic [15:0] asid,
                       bit wr, int drop_at);
    busy_cnt = 0;
    done_cnt = 0;
    drop_cnt = 0;
    bus.FlushReq = 1'b1;
    bus.FlushAll = all;
    bus.FlushASID = asid;
    if (wr) begin
      do_write(rnd_ppn(), 8'($urandom), 1'($urandom),
               16'($urandom_range(1, 3)));
      want("flush_wr_lands", K_VALIDS,
           64'(m_valids()));
    end else begin
      step();
    end
    bus.FlushReq = 1'b0;
    for (int c = 0; c < 4 * N && done_cnt == 0; c++) begin
      bus.WriteEn = (c == drop_at);
      bus.FlushReq = (drop_at >= 0 && c == drop_at + 2);
      bus.FlushAll = ~all;
      bus.FlushASID = ~asid;
      step();
    end
    bus.WriteEn = 1'b0;
    bus.FlushReq = 1'b0;
    for (int i = 0; i < N; i++)
      if (all || (m_asid[i] == asid && !m_g[i]))
        m_valid[i] = 1'b0;
    want("flush_busy_cycles", K_BUSYCNT, 64'(N + 1));
    want("flush_done_pulses", K_DONECNT, 64'd1);
    want("flush_dropped_wr", K_DROPCNT,
         64'(drop_at >= 0));
    check_state();
    step();
  endtask

  initial begin
    int op;
    int da;
    bus.PTE = '0;
    bus.WriteASID = '0;
    bus.WriteEn = 1'b0;
    bus.Matches = '0;
    bus.Hit = 1'b0;
    bus.FlushReq = 1'b0;
    bus.FlushAll = 1'b0;
    bus.FlushASID = '0;

    reset_dut();

    for (int i = 0; i < N; i++)
      do_write(PB'(i), 8'($urandom), 1'($urandom), 16'd1);
    check_state();
    do_read(N'(1) << 5);

    for (int i = 0; i < N - 1; i++) do_hit(i);
    check_state();
    do_write(rnd_ppn(), 8'($urandom), 1'b0, 16'd1);
    do_write(rnd_ppn(), 8'($urandom), 1'b0, 16'd1);
    check_state();

    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) do_read(rnd_match());
      else if (op < 6) do_hit($urandom_range(0, N - 1));
      else if (op < 9)
        do_write(rnd_ppn(), 8'($urandom), 1'($urandom),
                 16'($urandom_range(1, 3)));
      else begin
        da = ($urandom_range(0, 1) == 1) ? -1 :
             int'($urandom_range(0, 10));
        flush($urandom_range(0, 3) == 0,
              16'($urandom_range(1, 3)),
              1'($urandom), da);
      end
      if (n % 8 == 0) check_state();
    end
    do_read('0);

    reset_dut();
    for (int i = 0; i < N; i++)
      do_write(PB'(i), 8'($urandom), i == 3,
               (i == 2 || i == 3) ? 16'd7 : 16'd1);
    flush(1'b0, 16'd7, 1'b0, -1);
    do_read(N'(1) << 2);
    do_read(N'(1) << 3);

    flush(1'b1, 16'd0, 1'b1, 3);
    do_read('1);

    for (int i = 0; i < 8; i++)
      do_write(rnd_ppn(), 8'($urandom), 1'($urandom),
               16'd2);
    check_state();
    done_cnt = 0;
    bus.FlushReq = 1'b1;
    bus.FlushAll = 1'b1;
    step();
    bus.FlushReq = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    m_reset();
    bus.Matches = '1;
    #1;
    chk_now("midwalk_busy", K_BUSY, 64'd0);
    chk_now("midwalk_valids", K_VALIDS, 64'd0);
    chk_now("midwalk_ppn", K_PPN, 64'd0);
    chk_now("midwalk_victim", K_VICTIM, 64'd0);
    step();
    rst_n = 1'b1;
    repeat (N + 4) step();
    chk_now("midwalk_no_done", K_DONECNT, 64'd0);
    step();

    do_write(rnd_ppn(), 8'($urandom), 1'b1, 16'd4);
    check_state();
    do_read(N'(1));
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
